// File: rtl/uart_pkg.sv
// Shared definitions for the UART word streamer: FSM encoding, byte kinds,
// default sync byte and the word-to-byte count helper.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StNext,
        StTail,
        StCsum
    } state_e;

    // What the byte currently on tx_data is, so NEXT knows how to continue.
    typedef enum logic [1:0] {
        KindSync,
        KindData,
        KindCsum
    } kind_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic int unsigned bytes_per_word(input int unsigned word_w);
        return word_w / 8;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset and fall-through read
// (dout always shows the oldest entry while not empty).
module sync_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // Pointer and occupancy tracking; pointers wrap because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push_en && !pop_en) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (pop_en && !push_en) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_word_streamer.sv
// Feeds uart_tx_8n1 from a valid/ready word stream: buffers words, prefixes
// each frame with a sync byte and sends every word MSB byte first.
// Optional build macro UART_STREAM_CHECKSUM_EN appends an XOR checksum byte
// of the frame payload before frame_done.
module uart_tx_word_streamer
    import uart_pkg::*;
#(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        tx_data,
    output logic              tx_enable,
    input  logic              tx_busy,
    output logic              frame_done
);

    localparam int unsigned BYTES = bytes_per_word(WORD_W);
    localparam int unsigned IdxW  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES - 1);

    state_e            state_q;
    kind_e             kind_q;
    logic              sof_q;
    logic              last_q;
    logic              busy_prev_q;
    logic [WORD_W-1:0] shift_q;
    logic [IdxW-1:0]   byte_idx_q;
`ifdef UART_STREAM_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [WORD_W:0]             fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
    logic [WORD_W-1:0]           fifo_word;
    logic                        fifo_last;
    logic [WORD_W-1:0]           shifted;

    assign in_ready  = !fifo_full && !rst;
    assign fifo_push = in_valid && in_ready;
    assign fifo_word = fifo_dout[WORD_W-1:0];
    assign fifo_last = fifo_dout[WORD_W];
    assign shifted   = shift_q << 8;

    sync_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({in_last, in_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    // A word leaves the buffer only when its first byte is loaded; while the
    // sync byte is on the wire the word stays pending in the FIFO.
    always_comb begin
        fifo_pop = 1'b0;
        if (state_q == StIdle && !fifo_empty && !sof_q) fifo_pop = 1'b1;
        if (state_q == StNext && kind_q == KindSync)    fifo_pop = 1'b1;
    end

    // Byte sequencer with registered transmitter handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            kind_q      <= KindSync;
            sof_q       <= 1'b1;
            last_q      <= 1'b0;
            busy_prev_q <= 1'b1;
            shift_q     <= '0;
            byte_idx_q  <= '0;
            tx_data     <= 8'h00;
            tx_enable   <= 1'b0;
            frame_done  <= 1'b0;
`ifdef UART_STREAM_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            frame_done  <= 1'b0;
            busy_prev_q <= tx_busy;
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        tx_enable <= 1'b1;
                        state_q   <= StReq;
                        if (sof_q) begin
                            tx_data <= SYNC_BYTE;
                            kind_q  <= KindSync;
                        end else begin
                            shift_q    <= fifo_word;
                            last_q     <= fifo_last;
                            byte_idx_q <= '0;
                            tx_data    <= fifo_word[WORD_W-1 -: 8];
                            kind_q     <= KindData;
`ifdef UART_STREAM_CHECKSUM_EN
                            csum_q     <= csum_q ^ fifo_word[WORD_W-1 -: 8];
`endif
                        end
                    end
                end
                // Accept only a fresh rise of busy, so a transmitter still busy
                // from earlier traffic is never mistaken for an acceptance.
                StReq: begin
                    if (tx_busy && !busy_prev_q) begin
                        tx_enable <= 1'b0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (!tx_busy) state_q <= StNext;
                end
                StNext: begin
                    if (kind_q == KindSync) begin
                        sof_q      <= 1'b0;
                        shift_q    <= fifo_word;
                        last_q     <= fifo_last;
                        byte_idx_q <= '0;
                        tx_data    <= fifo_word[WORD_W-1 -: 8];
                        kind_q     <= KindData;
                        tx_enable  <= 1'b1;
                        state_q    <= StReq;
`ifdef UART_STREAM_CHECKSUM_EN
                        csum_q     <= csum_q ^ fifo_word[WORD_W-1 -: 8];
                    end else if (kind_q == KindCsum) begin
                        frame_done <= 1'b1;
                        sof_q      <= 1'b1;
                        csum_q     <= 8'h00;
                        state_q    <= StIdle;
`endif
                    end else if (byte_idx_q < LastIdx) begin
                        shift_q    <= shifted;
                        byte_idx_q <= byte_idx_q + IdxW'(1);
                        tx_data    <= shifted[WORD_W-1 -: 8];
                        tx_enable  <= 1'b1;
                        state_q    <= StReq;
`ifdef UART_STREAM_CHECKSUM_EN
                        csum_q     <= csum_q ^ shifted[WORD_W-1 -: 8];
`endif
                    end else if (last_q) begin
                        state_q <= StTail;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StTail: begin
`ifdef UART_STREAM_CHECKSUM_EN
                    state_q <= StCsum;
`else
                    frame_done <= 1'b1;
                    sof_q      <= 1'b1;
                    state_q    <= StIdle;
`endif
                end
                StCsum: begin
`ifdef UART_STREAM_CHECKSUM_EN
                    tx_data   <= csum_q;
                    kind_q    <= KindCsum;
                    tx_enable <= 1'b1;
                    state_q   <= StReq;
`else
                    state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
